// File: rtl/neo_sdram_arb.sv
// rtl/neo_sdram_arb.sv - NeoGeo ROM read arbiter/sequencer in front of the shared SDRAM controller
module neo_sdram_arb (
  input  logic        clk_sys,
  input  logic        nRESET,
  input  logic        dl_active,
  input  logic [24:0] dl_addr,
  input  logic        dl_wr,
  input  logic        prom_req,
  input  logic        prom_sys,
  input  logic [18:0] prom_addr,
  output logic [15:0] prom_data,
  output logic        prom_valid,
  input  logic        srom_req,
  input  logic [16:0] srom_addr,
  output logic [7:0]  fixd,
  output logic        srom_valid,
  input  logic        crom_req,
  input  logic [20:0] crom_addr,
  output logic [31:0] cr,
  output logic        crom_valid,
  output logic [24:0] sdram_addr,
  output logic        sdram_rd,
  output logic        sdram_we,
  input  logic        sdram_ready,
  input  logic [15:0] sdram_dout,
  output logic        busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT_BUSY, ST_WAIT_DONE, ST_CSTEP} state_t;
  typedef enum logic [1:0] {SRC_P, SRC_S, SRC_C} src_t;

  // Request bit order everywhere: [2]=CROM, [1]=SROM, [0]=PROM.
  logic [2:0]  req_smp_q, req_dly1_q, req_dly2_q;
  logic [2:0]  req_edge;
  logic [2:0]  pend_q, pend_d;
  state_t      state_q, state_d;
  src_t        src_q, src_d;
  logic        step_q, step_d;
  logic        fix_hi_q, fix_hi_d;
  logic [24:0] addr_q, addr_d;
  logic        rd_q, rd_d;
  logic [15:0] prom_data_q, prom_data_d;
  logic [7:0]  fixd_q, fixd_d;
  logic [31:0] cr_q, cr_d;
  logic [15:0] cr_hi_q, cr_hi_d;
  logic        pv_q, pv_d, sv_q, sv_d, cv_q, cv_d;

  function automatic logic [24:0] crom_map(input logic [20:0] a, input logic s);
    return {2'b00, a, s, 1'b0} + 25'h0100000;
  endfunction

  assign req_edge = req_dly1_q & ~req_dly2_q;

  // Request sampling and edge pipeline; never reset so a level held across reset or download makes no edge.
  always_ff @(posedge clk_sys) begin
    req_smp_q  <= {crom_req, srom_req, prom_req};
    req_dly1_q <= req_smp_q;
    req_dly2_q <= req_dly1_q;
  end

  // Grant, access sequencing and data capture; download mode overrides everything.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q | req_edge;
    src_d       = src_q;
    step_d      = step_q;
    fix_hi_d    = fix_hi_q;
    addr_d      = addr_q;
    rd_d        = 1'b0;
    prom_data_d = prom_data_q;
    fixd_d      = fixd_q;
    cr_d        = cr_q;
    cr_hi_d     = cr_hi_q;
    pv_d        = 1'b0;
    sv_d        = 1'b0;
    cv_d        = 1'b0;
    if (dl_active) begin
      state_d = ST_IDLE;
      pend_d  = 3'b000;
      step_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sdram_ready && (pend_q != 3'b000)) begin
            rd_d    = 1'b1;
            state_d = ST_WAIT_BUSY;
            if (pend_q[2]) begin
              src_d     = SRC_C;
              step_d    = 1'b0;
              addr_d    = crom_map(crom_addr, 1'b0);
              pend_d[2] = req_edge[2];
            end else if (pend_q[1]) begin
              src_d     = SRC_S;
              fix_hi_d  = srom_addr[0];
              addr_d    = {8'b00000100, srom_addr[16:1], 1'b0};
              pend_d[1] = req_edge[1];
            end else begin
              src_d     = SRC_P;
              addr_d    = prom_sys ? {7'b0011100, prom_addr[17:1], 1'b0}
                                   : {5'b00000, prom_addr, 1'b0};
              pend_d[0] = req_edge[0];
            end
          end
        end
        ST_WAIT_BUSY: begin
          if (!sdram_ready) state_d = ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (sdram_ready) begin
            state_d = ST_IDLE;
            case (src_q)
              SRC_P: begin
                prom_data_d = {sdram_dout[7:0], sdram_dout[15:8]};
                pv_d        = 1'b1;
              end
              SRC_S: begin
                fixd_d = fix_hi_q ? sdram_dout[15:8] : sdram_dout[7:0];
                sv_d   = 1'b1;
              end
              default: begin
                if (!step_q) begin
                  cr_hi_d = sdram_dout;
                  state_d = ST_CSTEP;
                end else begin
                  cr_d = {cr_hi_q, sdram_dout};
                  cv_d = 1'b1;
                end
              end
            endcase
          end
        end
        default: begin
          step_d  = 1'b1;
          addr_d  = crom_map(crom_addr, 1'b1);
          rd_d    = 1'b1;
          state_d = ST_WAIT_BUSY;
        end
      endcase
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      state_q     <= ST_IDLE;
      pend_q      <= 3'b000;
      src_q       <= SRC_P;
      step_q      <= 1'b0;
      fix_hi_q    <= 1'b0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      prom_data_q <= '0;
      fixd_q      <= '0;
      cr_q        <= '0;
      cr_hi_q     <= '0;
      pv_q        <= 1'b0;
      sv_q        <= 1'b0;
      cv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      src_q       <= src_d;
      step_q      <= step_d;
      fix_hi_q    <= fix_hi_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      prom_data_q <= prom_data_d;
      fixd_q      <= fixd_d;
      cr_q        <= cr_d;
      cr_hi_q     <= cr_hi_d;
      pv_q        <= pv_d;
      sv_q        <= sv_d;
      cv_q        <= cv_d;
    end
  end

  assign sdram_addr = dl_active ? dl_addr : addr_q;
  assign sdram_rd   = rd_q & ~dl_active;
  assign sdram_we   = dl_active & dl_wr;
  assign busy       = (state_q != ST_IDLE);
  assign prom_data  = prom_data_q;
  assign prom_valid = pv_q;
  assign fixd       = fixd_q;
  assign srom_valid = sv_q;
  assign cr         = cr_q;
  assign crom_valid = cv_q;

endmodule

// File: tb/tb_neo_sdram_arb.sv
// tb/tb_neo_sdram_arb.sv - self-checking bench for neo_sdram_arb
module tb_neo_sdram_arb;

  logic        clk_sys = 1'b0;
  logic        nRESET, dl_active, dl_wr, prom_req, prom_sys, srom_req, crom_req, sdram_ready;
  logic [24:0] dl_addr;
  logic [18:0] prom_addr;
  logic [16:0] srom_addr;
  logic [20:0] crom_addr;
  logic [15:0] sdram_dout, prom_data;
  logic [7:0]  fixd;
  logic [31:0] cr;
  logic [24:0] sdram_addr;
  logic        prom_valid, srom_valid, crom_valid, sdram_rd, sdram_we, busy;

  always #5 clk_sys = ~clk_sys;

  neo_sdram_arb dut (
    .clk_sys(clk_sys), .nRESET(nRESET), .dl_active(dl_active), .dl_addr(dl_addr), .dl_wr(dl_wr),
    .prom_req(prom_req), .prom_sys(prom_sys), .prom_addr(prom_addr), .prom_data(prom_data),
    .prom_valid(prom_valid), .srom_req(srom_req), .srom_addr(srom_addr), .fixd(fixd),
    .srom_valid(srom_valid), .crom_req(crom_req), .crom_addr(crom_addr), .cr(cr),
    .crom_valid(crom_valid), .sdram_addr(sdram_addr), .sdram_rd(sdram_rd), .sdram_we(sdram_we),
    .sdram_ready(sdram_ready), .sdram_dout(sdram_dout), .busy(busy)
  );

  localparam int K_NONE = 0, K_P = 1, K_S = 2, K_C0 = 3, K_C1 = 4;

  typedef struct {
    int          kind;
    logic [24:0] addr;
    logic        lowbit;
  } xact_t;

  int          checks = 0, errors = 0;
  int          cyc = 0;
  xact_t       exp_q[$];
  xact_t       cur;
  int          inflight_kind = K_NONE;
  logic        inflight_low = 1'b0;
  logic [15:0] force_q[$];
  logic [15:0] last_word = '0, c0_word = '0;
  int          last_cap_cyc = -10, last_rd_cyc = -10;
  logic [24:0] rd_log[$];
  int          rd_cnt = 0, n_pv = 0, n_sv = 0, n_cv = 0;
  int          hold_ovr = 0;
  bit          resp_busy = 1'b0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Address map written as plain arithmetic on the request fields.
  function automatic logic [24:0] prom_map(input logic sys, input logic [18:0] a);
    if (sys) return 25'h0700000 | (25'(a) & 25'h003FFFE);
    return 25'(a) * 2;
  endfunction
  function automatic logic [24:0] fix_map(input logic [16:0] s);
    return 25'h0080000 | (25'(s) & 25'h001FFFE);
  endfunction
  function automatic logic [24:0] crom_map(input logic [20:0] c, input int step);
    return 25'(c) * 4 + 25'(step) * 2 + 25'h0100000;
  endfunction
  function automatic xact_t mk(input int k, input logic [24:0] a, input logic lb);
    xact_t x;
    x.kind = k; x.addr = a; x.lowbit = lb;
    return x;
  endfunction

  // SDRAM controller model: ready drops 0-1 cycles after rd, stays low a while, then returns with data.
  initial begin
    logic [15:0] word;
    int          lo;
    sdram_ready = 1'b1;
    sdram_dout  = '0;
    forever begin
      @(negedge clk_sys);
      if (sdram_rd) begin
        resp_busy = 1'b1;
        if (force_q.size() > 0) word = force_q.pop_front();
        else word = 16'($urandom);
        if ($urandom_range(0, 1) == 1) @(negedge clk_sys);
        sdram_ready = 1'b0;
        lo = (hold_ovr != 0) ? hold_ovr : int'($urandom_range(1, 4));
        repeat (lo) @(negedge clk_sys);
        sdram_ready  = 1'b1;
        sdram_dout   = word;
        last_word    = word;
        last_cap_cyc = cyc + 1;
        resp_busy    = 1'b0;
      end
    end
  end

  // Per-cycle compare against the expected transaction stream.
  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      if (!nRESET) begin
        check("rst_addr", sdram_addr, 0);
        check("rst_ctl", {sdram_rd, prom_valid, srom_valid, crom_valid, busy}, 0);
        check("rst_prom_data", prom_data, 0);
        check("rst_fixd", fixd, 0);
        check("rst_cr", cr, 0);
        inflight_kind = K_NONE;
      end else if (dl_active) begin
        check("dl_addr", sdram_addr, dl_addr);
        check("dl_we", sdram_we, dl_wr);
        check("dl_rd", sdram_rd, 0);
        check("dl_busy", busy, 0);
        check("dl_valid", {prom_valid, srom_valid, crom_valid}, 0);
      end else begin
        check("we_outside_dl", sdram_we, 0);
        if (sdram_rd) begin
          rd_cnt++;
          last_rd_cyc = cyc;
          rd_log.push_back(sdram_addr);
          check("rd_ready", sdram_ready, 1);
          check("rd_busy", busy, 1);
          check("rd_expected", 32'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("rd_addr", sdram_addr, cur.addr);
            if (cur.kind == K_C1) begin
              check("c1_gap", cyc, last_cap_cyc + 1);
              check("c1_after_c0", inflight_kind, K_C0);
              c0_word = last_word;
            end
            inflight_kind = cur.kind;
            inflight_low  = cur.lowbit;
          end
        end
        if (prom_valid) begin
          n_pv++;
          check("pv_kind", inflight_kind, K_P);
          check("pv_time", cyc, last_cap_cyc);
          check("prom_data", prom_data, {last_word[7:0], last_word[15:8]});
          inflight_kind = K_NONE;
        end
        if (srom_valid) begin
          n_sv++;
          check("sv_kind", inflight_kind, K_S);
          check("sv_time", cyc, last_cap_cyc);
          check("fixd", fixd, inflight_low ? last_word[15:8] : last_word[7:0]);
          inflight_kind = K_NONE;
        end
        if (crom_valid) begin
          n_cv++;
          check("cv_kind", inflight_kind, K_C1);
          check("cv_time", cyc, last_cap_cyc);
          check("cr", cr, {c0_word, last_word});
          inflight_kind = K_NONE;
        end
      end
    end
  end

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk_sys);
      done = (exp_q.size() == 0) && (inflight_kind == K_NONE) && !resp_busy && !busy && sdram_ready;
    end
    check(name, 32'(done), 1);
    repeat (3) @(negedge clk_sys);
  endtask

  task automatic wait_rd(input string name, input int rd0);
    bit done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk_sys);
      done = (rd_cnt > rd0);
    end
    check(name, 32'(done), 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rd0, pv0, sv0, cv0, t0;
    logic [2:0]  mask;
    logic [18:0] pa;
    logic [16:0] sa;
    logic [20:0] ca;
    logic        ps;
    bit          low_seen;

    nRESET = 1'b0; dl_active = 1'b0; dl_addr = '0; dl_wr = 1'b0;
    prom_req = 1'b0; prom_sys = 1'b0; prom_addr = '0;
    srom_req = 1'b0; srom_addr = '0; crom_req = 1'b0; crom_addr = '0;

    // Reset with request inputs toggling.
    repeat (4) begin
      @(negedge clk_sys);
      prom_req = 1'($urandom); srom_req = 1'($urandom); crom_req = 1'($urandom);
    end
    @(negedge clk_sys);
    prom_req = 1'b0; srom_req = 1'b0; crom_req = 1'b0;
    repeat (4) @(negedge clk_sys);
    nRESET = 1'b1;
    repeat (3) @(negedge clk_sys);
    check("post_reset_rd_count", rd_cnt, 0);

    // Single PROM read with latency and formatting pinned.
    prom_sys = 1'b0; prom_addr = 19'h00123;
    force_q.push_back(16'hABCD);
    exp_q.push_back(mk(K_P, prom_map(1'b0, 19'h00123), 1'b0));
    rd0 = rd_cnt; pv0 = n_pv;
    t0 = cyc + 1;
    prom_req = 1'b1;
    repeat (2) @(negedge clk_sys);
    prom_req = 1'b0;
    wait_idle("t2_idle");
    check("t2_rd_latency", last_rd_cyc, t0 + 3);
    check("t2_addr_hold", sdram_addr, 25'h000246);
    check("t2_prom_data", prom_data, 16'hCDAB);
    check("t2_pv_count", n_pv - pv0, 1);
    check("t2_rd_count", rd_cnt - rd0, 1);

    // Simultaneous SROM and PROM strobes: fix first.
    srom_addr = 17'h00005;
    force_q.push_back(16'h1234);
    exp_q.push_back(mk(K_S, fix_map(17'h00005), 1'b1));
    exp_q.push_back(mk(K_P, prom_map(1'b0, 19'h00123), 1'b0));
    rd0 = rd_log.size();
    srom_req = 1'b1; prom_req = 1'b1;
    repeat (2) @(negedge clk_sys);
    srom_req = 1'b0; prom_req = 1'b0;
    wait_idle("t3_idle");
    check("t3_first_addr", rd_log[rd0], 25'h080004);
    check("t3_second_addr", rd_log[rd0 + 1], 25'h000246);
    check("t3_fixd", fixd, 8'h12);

    // CROM pair is atomic even with a PROM edge during word 0.
    crom_addr = 21'h000010;
    force_q.push_back(16'h1111);
    force_q.push_back(16'h2222);
    exp_q.push_back(mk(K_C0, crom_map(21'h000010, 0), 1'b0));
    exp_q.push_back(mk(K_C1, crom_map(21'h000010, 1), 1'b0));
    rd0 = rd_log.size(); pv0 = n_pv; cv0 = n_cv;
    crom_req = 1'b1;
    wait_rd("t4_first_rd", rd_cnt);
    @(negedge clk_sys);
    exp_q.push_back(mk(K_P, prom_map(1'b0, 19'h00123), 1'b0));
    prom_req = 1'b1;
    repeat (2) @(negedge clk_sys);
    crom_req = 1'b0; prom_req = 1'b0;
    wait_idle("t4_idle");
    check("t4_word0_addr", rd_log[rd0], 25'h100040);
    check("t4_word1_addr", rd_log[rd0 + 1], 25'h100042);
    check("t4_prom_addr", rd_log[rd0 + 2], 25'h000246);
    check("t4_cr", cr, 32'h11112222);
    check("t4_cv_count", n_cv - cv0, 1);
    check("t4_pv_count", n_pv - pv0, 1);

    // Download pass-through; PROM level held across exit makes no read.
    rd0 = rd_cnt;
    dl_active = 1'b1; dl_addr = 25'h0ABCDE;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_sys);
      dl_wr = 1'(i);
      if (i == 2) prom_req = 1'b1;
      #1;
      check("t5_addr", sdram_addr, 25'h0ABCDE);
      check("t5_we", sdram_we, 32'(i & 1));
    end
    @(negedge clk_sys);
    dl_active = 1'b0; dl_wr = 1'b0;
    repeat (10) @(negedge clk_sys);
    check("t5_no_rd_after_exit", rd_cnt - rd0, 0);
    prom_req = 1'b0;
    repeat (4) @(negedge clk_sys);

    // Reset while WAIT_DONE; next grant lines up with ready returning.
    hold_ovr = 14;
    pv0 = n_pv; sv0 = n_sv;
    exp_q.push_back(mk(K_P, prom_map(1'b0, 19'h00123), 1'b0));
    prom_req = 1'b1;
    wait_rd("t6_rd", rd_cnt);
    @(negedge clk_sys);
    prom_req = 1'b0;
    low_seen = 1'b0;
    for (int i = 0; i < 10 && !low_seen; i++) begin
      @(posedge clk_sys);
      #1;
      low_seen = !sdram_ready;
    end
    check("t6_ready_dropped", 32'(low_seen), 1);
    repeat (2) @(negedge clk_sys);
    nRESET = 1'b0;
    repeat (2) @(negedge clk_sys);
    nRESET = 1'b1;
    hold_ovr = 0;
    srom_addr = 17'h0A3C4;
    exp_q.push_back(mk(K_S, fix_map(17'h0A3C4), 1'b0));
    rd0 = rd_cnt;
    srom_req = 1'b1;
    repeat (2) @(negedge clk_sys);
    srom_req = 1'b0;
    wait_rd("t6_new_rd", rd0);
    check("t6_grant_at_ready", last_rd_cyc, last_cap_cyc);
    wait_idle("t6_idle");
    check("t6_no_prom_valid", n_pv - pv0, 0);
    check("t6_sv_count", n_sv - sv0, 1);

    // Randomised bursts of simultaneous strobes.
    for (int t = 0; t < 40; t++) begin
      mask = 3'($urandom_range(1, 7));
      pa = 19'($urandom); sa = 17'($urandom); ca = 21'($urandom); ps = 1'($urandom);
      @(negedge clk_sys);
      prom_sys = ps; prom_addr = pa; srom_addr = sa; crom_addr = ca;
      pv0 = n_pv; sv0 = n_sv; cv0 = n_cv;
      if (mask[2]) begin
        exp_q.push_back(mk(K_C0, crom_map(ca, 0), 1'b0));
        exp_q.push_back(mk(K_C1, crom_map(ca, 1), 1'b0));
      end
      if (mask[1]) exp_q.push_back(mk(K_S, fix_map(sa), sa[0]));
      if (mask[0]) exp_q.push_back(mk(K_P, prom_map(ps, pa), 1'b0));
      @(negedge clk_sys);
      crom_req = mask[2]; srom_req = mask[1]; prom_req = mask[0];
      repeat ($urandom_range(1, 6)) @(negedge clk_sys);
      crom_req = 1'b0; srom_req = 1'b0; prom_req = 1'b0;
      wait_idle("rand_idle");
      check("rand_pv_count", n_pv - pv0, 32'(mask[0]));
      check("rand_sv_count", n_sv - sv0, 32'(mask[1]));
      check("rand_cv_count", n_cv - cv0, 32'(mask[2]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/neo_sdram_arb.md
# neo_sdram_arb

Read-request arbiter and sequencer that shares the single 16-bit SDRAM controller between the three NeoGeo ROM consumers: P ROM/system ROM (68k), fix S ROM (NEO-B1 via FIXD), and sprite C ROM (ZMC2 via the 32-bit CR bus). It sits between the request strobes derived from nROMOE/nSROMOE, PCK2/S2H1 and PCK1 and the `sdram` controller's `addr/rd/ready/dout` port. It also hands the port to hps_io during cartridge download. It serialises reads, maps each requester into the SDRAM layout, and returns formatted data with one-cycle valid pulses.

## Interface
No parameters; the address map is fixed.
- `clk_sys` in 1: system clock (144 MHz); all logic on rising edge.
- `nRESET` in 1: synchronous, active-low reset.
- `dl_active` in 1: cartridge download in progress (ioctl_download).
- `dl_addr` in 25: download byte address.
- `dl_wr` in 1: download write strobe.
- `prom_req` in 1: level; high while ~nROMOE | ~nSROMOE.
- `prom_sys` in 1: 1 = system ROM, 0 = cart P ROM.
- `prom_addr` in 19: M68K_ADDR[19:1].
- `prom_data` out 16: last P/system ROM word, byte-swapped.
- `prom_valid` out 1: one-cycle pulse when `prom_data` updates.
- `srom_req` in 1: fix fetch strobe (~PCK2 OR S2H1, pre-combined).
- `srom_addr` in 17: FIX_ROM_ADDR.
- `fixd` out 8: fix byte.
- `srom_valid` out 1: one-cycle pulse when `fixd` updates.
- `crom_req` in 1: sprite fetch strobe (~PCK1).
- `crom_addr` in 21: SPR_ROM_ADDR.
- `cr` out 32: sprite data.
- `crom_valid` out 1: one-cycle pulse when `cr` updates.
- `sdram_addr` out 25: controller address (LSB always 0 for reads).
- `sdram_rd` out 1: one-cycle read pulse.
- `sdram_we` out 1: write strobe (download only).
- `sdram_ready` in 1: controller idle/done.
- `sdram_dout` in 16: controller read data.
- `busy` out 1: state ≠ IDLE.

## Operation
- **Edge detect.** Each of `prom_req`, `srom_req` and `crom_req` passes through a 2-flop shift register. An observed 0→1 transition sets a pending flag (`p_pend`, `s_pend`, `c_pend`). A repeated edge while a flag is already set merges into the one pending request. An edge during service of that same requester sets the flag again as a new request.
- **Grant priority** (in IDLE with `sdram_ready`=1): CROM > SROM > PROM. Each grant clears its pending flag and latches the requester's address into `sdram_addr`.
- **Address map.**
  - PROM: {5'b0, prom_addr, 1'b0}.
  - System ROM: {7'b0011100, prom_addr[17:1], 1'b0}.
  - Fix: {8'b00000100, srom_addr[16:1], 1'b0}.
  - CROM: {2'b0, crom_addr, step, 1'b0} + 25'h0100000, with 25-bit arithmetic and wrap-around ignored.
- **States.**
  - IDLE: on a grant, assert `sdram_rd` for one cycle and go to WAIT_BUSY.
  - WAIT_BUSY: wait for `sdram_ready`=0, then go to WAIT_DONE.
  - WAIT_DONE: wait for `sdram_ready`=1, capture `sdram_dout`, then go to IDLE. For CROM step 0, go to CSTEP instead.
  - CSTEP: set step=1, re-latch the CROM address and pulse `sdram_rd`, then go to WAIT_BUSY.
  - A CROM access is atomic: no other requester is granted between its two words.
- **Capture formatting.**
  - `prom_data` = {dout[7:0], dout[15:8]}.
  - `fixd` = srom_addr[0] ? dout[15:8] : dout[7:0], using the address latched at grant.
  - CROM step 0 goes to an internal `cr_hi` register. Step 1 updates `cr` = {cr_hi, dout} atomically and pulses `crom_valid`.
  - `cr` never shows a half-updated word.
- **Download mode** (`dl_active`=1):
  - Forces IDLE and clears all pending flags and the CROM step.
  - `sdram_rd`=0, `sdram_addr`=`dl_addr` (combinational pass-through), `sdram_we`=`dl_wr`.
  - Edge-detector flops keep sampling, so a level already high at download exit does not create an edge.
  - Outside download, `sdram_we`=0.
- **Reset** (`nRESET`=0, synchronous): state IDLE, all flags and step cleared. All outputs 0: `sdram_addr`, `sdram_rd`, `prom_data`, `fixd`, `cr`, the valid pulses and `busy`. Reset mid-access abandons the access without a valid pulse. The next grant still waits for `sdram_ready`=1.

## Timing
- **Request latency.** A request input rising before edge N sets its pending flag at edge N+2. `sdram_rd` is high in cycle N+3 if the block is IDLE and `sdram_ready`=1.
- **`sdram_addr` hold.** Stable from the `sdram_rd` cycle until the next grant.
- **Data capture.** The valid pulse and the data-register update happen on the same edge: the first edge at which WAIT_DONE sees `sdram_ready`=1.
- **CROM second word.** Issued exactly 1 cycle after the first word is captured.
- **Simultaneous edges.** All flags set; service order is C, then S, then P. Each valid pulse appears in a separate access.
- **No timeout.** WAIT_BUSY and WAIT_DONE have no timeout. The controller guarantees `ready` drops within 2 cycles of `rd`.

## Test plan
1. **Reset.** Hold `nRESET`=0 for 4 cycles with all requests toggling → all outputs 0, `busy`=0, no `sdram_rd`.
2. **PROM read.** `prom_sys`=0, `prom_addr`=19'h00123, `prom_req`↑; the model returns 16'hABCD → `sdram_addr`=25'h000246, one `sdram_rd` pulse, `prom_data`=16'hCDAB, one `prom_valid` pulse.
3. **Simultaneous strobes.** `srom_req` and `prom_req` rise on the same edge; `srom_addr`=17'h00005; dout=16'h1234 → fix serviced first at `sdram_addr`=25'h080004, `fixd`=8'h12, then the PROM access.
4. **CROM atomicity.** `crom_addr`=21'h000010, `crom_req`↑, `prom_req`↑ during word 0; words 16'h1111/16'h2222 → addresses 25'h100040 then 25'h100042 back-to-back, `cr`=32'h11112222, single `crom_valid`, PROM issued only afterwards.
5. **Download.** `dl_active`=1, `dl_wr` pulses, `dl_addr`=25'h0ABCDE → `sdram_addr` follows, `sdram_we`=`dl_wr`, `sdram_rd`=0. `prom_req` held high across the exit → no read issued after exit.
6. **Reset mid-access.** Assert `nRESET`=0 during WAIT_DONE → no valid pulse, state IDLE. A new request waits for `sdram_ready`=1 before `sdram_rd`.
